cpu_mul_unit: RTL

CPU_MUL_UNIT -- requirements
Module: cpu_mul_unit

---
 rtl/cpu_mul_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_mul_unit.sv
// Pipelined integer multiplier with a per-stage writeback scoreboard for hazard detection.
// Operands register in stage 0, partial products in stage 1, the selected half from stage 2 onward.
module cpu_mul_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int STAGES   = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_valid,
    input  logic [REG_ID_W-1:0]                issue_rd_id,
    input  logic [DATA_W-1:0]                  issue_a,
    input  logic [DATA_W-1:0]                  issue_b,
    input  logic                               issue_high,
    input  logic                               issue_signed,
    input  logic                               stall,
    output logic [STAGES-1:0]                  slot_wb,
    output logic [STAGES-1:0][REG_ID_W-1:0]    slot_rd_id,
    output logic                               wb_valid,
    output logic                               wb_fire,
    output logic [REG_ID_W-1:0]                wb_rd_id,
    output logic [DATA_W-1:0]                  wb_data,
    output logic [2:0]                         busy_cnt
);

    // Operands carry one extra sign bit so one multiplier serves signed and unsigned issues.
    localparam int W1 = DATA_W + 1;
    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    logic [STAGES-1:0]                 wb_r;
    logic [STAGES-1:0][REG_ID_W-1:0]   rd_r;
    logic [2:0]                        busy_r;

    logic [W1-1:0]                     op_a_r;
    logic [W1-1:0]                     op_b_r;
    logic                              high0_r;
    logic [PW-1:0]                     pp_lo_r;
    logic [PW-1:0]                     pp_hi_r;
    logic                              high1_r;
    logic [DATA_W-1:0]                 res_r [2:STAGES-1];

    logic                              issue_wb_s;
    logic [REG_ID_W-1:0]               issue_id_s;
    logic [W1-1:0]                     a_ext_s;
    logic [W1-1:0]                     b_ext_s;
    logic [PW-1:0]                     a_w_s;
    logic [PW-1:0]                     b_lo_w_s;
    logic [PW-1:0]                     b_hi_w_s;
    logic [PW-1:0]                     pp_lo_s;
    logic [PW-1:0]                     pp_hi_s;
    logic [PW-1:0]                     product_s;
    logic [DATA_W-1:0]                 result_s;
    logic                              fire_s;

    // A write to r0 never needs tracking, so it travels as a bubble.
    assign issue_wb_s = issue_valid && (issue_rd_id != {REG_ID_W{1'b0}});
    assign issue_id_s = issue_wb_s ? issue_rd_id : {REG_ID_W{1'b0}};
    assign a_ext_s    = {issue_signed & issue_a[DATA_W-1], issue_a};
    assign b_ext_s    = {issue_signed & issue_b[DATA_W-1], issue_b};

    // b is split into an unsigned low half and a signed upper part; the product is
    // only needed modulo 2^PW, so plain PW-wide unsigned multiplies are exact.
    assign a_w_s     = {{(PW-W1){op_a_r[W1-1]}}, op_a_r};
    assign b_lo_w_s  = {{(PW-H){1'b0}}, op_b_r[H-1:0]};
    assign b_hi_w_s  = {{(PW-W1+H){op_b_r[W1-1]}}, op_b_r[W1-1:H]};
    assign pp_lo_s   = a_w_s * b_lo_w_s;
    assign pp_hi_s   = a_w_s * b_hi_w_s;
    assign product_s = pp_lo_r + (pp_hi_r << H);

    // Select the requested half of the recombined product.
    always_comb begin
        result_s = {DATA_W{1'b0}};
        if (high1_r) begin
            result_s = product_s[PW-1:DATA_W];
        end else begin
            result_s = product_s[DATA_W-1:0];
        end
    end

    assign fire_s = wb_r[STAGES-1] & ~stall;

    // Scoreboard shift register: pending-writeback flags and destination ids.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_r <= {STAGES{1'b0}};
            rd_r <= {(STAGES*REG_ID_W){1'b0}};
        end else if (!stall) begin
            wb_r <= {wb_r[STAGES-2:0], issue_wb_s};
            rd_r <= {rd_r[STAGES-2:0], issue_id_s};
        end
    end

    // Datapath stages: operands, partial products, then the selected result travels to the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_r  <= {W1{1'b0}};
            op_b_r  <= {W1{1'b0}};
            high0_r <= 1'b0;
            pp_lo_r <= {PW{1'b0}};
            pp_hi_r <= {PW{1'b0}};
            high1_r <= 1'b0;
            for (int k = 2; k < STAGES; k++) begin
                res_r[k] <= {DATA_W{1'b0}};
            end
        end else if (!stall) begin
            op_a_r  <= a_ext_s;
            op_b_r  <= b_ext_s;
            high0_r <= issue_high;
            pp_lo_r <= pp_lo_s;
            pp_hi_r <= pp_hi_s;
            high1_r <= high0_r;
            res_r[2] <= result_s;
            for (int k = 3; k < STAGES; k++) begin
                res_r[k] <= res_r[k-1];
            end
        end
    end

    // Occupancy counter kept in step with the popcount of the writeback flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 3'd0;
        end else if (!stall) begin
            case ({issue_wb_s, fire_s})
                2'b10:   busy_r <= busy_r + 3'd1;
                2'b01:   busy_r <= busy_r - 3'd1;
                default: busy_r <= busy_r;
            endcase
        end
    end

    assign slot_wb    = wb_r;
    assign slot_rd_id = rd_r;
    assign wb_valid   = wb_r[STAGES-1];
    assign wb_fire    = fire_s;
    assign wb_rd_id   = rd_r[STAGES-1];
    assign wb_data    = res_r[STAGES-1];
    assign busy_cnt   = busy_r;

endmodule
